// File: rtl/mux_varredura.sv
// mux_varredura: registered N-channel, W-bit multiplexer with valid/ready output.
//
// Picks one of CHANNELS input words, either on an explicit manual request or (optionally)
// by round-robin scanning, and holds the word plus its channel index in an output slot
// under valid/ready flow control. A capture is never dropped: scanning stalls while the
// slot is occupied and resumes on the same channel.
//
// Optional feature: define MUX_AUTOSCAN_EN to compile in the scan mode (dwell counter,
// channel counter and scan states). Without it the block is manual-only and `mode` is
// ignored.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   data_in    CHANNELS*WIDTH packed words, channel c at [c*WIDTH +: WIDTH]
//   sel_in     manual channel select
//   load       manual capture request, sampled every cycle
//   mode       0 = manual, 1 = scan (only with MUX_AUTOSCAN_EN)
//   out_data   captured word
//   out_chan   channel index of out_data
//   out_valid  out_data/out_chan hold a capture
//   out_ready  downstream accept (transfer on out_valid && out_ready)
//   sel_err    one-cycle pulse after a manual capture with sel_in >= CHANNELS

module mux_varredura #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned SEL_W    = 3,
    parameter int unsigned DWELL    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]          sel_in,
    input  logic                      load,
    input  logic                      mode,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      sel_err
);

    localparam logic [SEL_W-1:0] CHAN_LAST = SEL_W'(CHANNELS - 1);

    logic [WIDTH-1:0] out_data_q;
    logic [SEL_W-1:0] out_chan_q;
    logic             out_valid_q;
    logic             sel_err_q;

    logic             slot_free;
    logic             sel_oor;
    logic             capture;
    logic             cap_err;
    logic [SEL_W-1:0] pick_sel;
    logic [WIDTH-1:0] pick_word;

    assign slot_free = !out_valid_q || out_ready;
    assign sel_oor   = (sel_in > CHAN_LAST);

    // Out-of-range indices match no channel and therefore yield an all-zero word.
    always_comb begin
        pick_word = '0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            if (pick_sel == SEL_W'(c)) begin
                pick_word = data_in[c*WIDTH +: WIDTH];
            end
        end
    end

`ifdef MUX_AUTOSCAN_EN
    localparam int unsigned      DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);

    typedef enum logic [1:0] {
        StManual,
        StScanWait,
        StScanStall
    } state_e;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] chan_q, chan_d;
    logic [DW_W-1:0]  dwell_q, dwell_d;
    logic [SEL_W-1:0] chan_next;
    logic             unused_cfg;

    assign unused_cfg = 1'b0;
    assign chan_next  = (chan_q == CHAN_LAST) ? '0 : chan_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        chan_d   = chan_q;
        dwell_d  = dwell_q;
        capture  = 1'b0;
        cap_err  = 1'b0;
        pick_sel = sel_in;
        unique case (state_q)
            StManual: begin
                if (mode) begin
                    // chan_q is retained so scanning resumes where it left off.
                    state_d = StScanWait;
                    dwell_d = '0;
                end else if (load && slot_free) begin
                    capture = 1'b1;
                    cap_err = sel_oor;
                end
            end
            StScanWait: begin
                pick_sel = chan_q;
                if (!mode) begin
                    state_d = StManual;
                end else if (dwell_q == DWELL_LAST) begin
                    if (slot_free) begin
                        capture = 1'b1;
                        chan_d  = chan_next;
                        dwell_d = '0;
                    end else begin
                        state_d = StScanStall;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            StScanStall: begin
                pick_sel = chan_q;
                if (!mode) begin
                    state_d = StManual;
                end else if (slot_free) begin
                    capture = 1'b1;
                    chan_d  = chan_next;
                    dwell_d = '0;
                    state_d = StScanWait;
                end
            end
            default: state_d = StManual;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StManual;
            chan_q  <= '0;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            dwell_q <= dwell_d;
        end
    end
`else
    // Manual-only build: mode and the scan period are don't-cares.
    logic unused_cfg;

    assign unused_cfg = mode ^ (DWELL == 0);

    always_comb begin
        pick_sel = sel_in;
        capture  = load && slot_free;
        cap_err  = load && slot_free && sel_oor;
    end
`endif

    // Output slot: a capture always wins over an accept, so accept+capture in one cycle
    // keeps out_valid high with the new word (no bubble).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
        end else begin
            sel_err_q <= cap_err;
            if (capture) begin
                out_data_q  <= pick_word;
                out_chan_q  <= pick_sel;
                out_valid_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;
    assign sel_err   = sel_err_q;

endmodule
